// File: rtl/crossing_scheduler.sv
// crossing_scheduler: right-of-way sequencer for a main/side road crossing
// with a shared pedestrian walk phase and a flashing-mode override.
module crossing_scheduler #(
    parameter int unsigned C_MIN_GREEN = 6,
    parameter int unsigned C_SIDE_MIN  = 4,
    parameter int unsigned C_SIDE_MAX  = 10,
    parameter int unsigned C_YELLOW    = 2,
    parameter int unsigned C_ALL_RED   = 1,
    parameter int unsigned C_WALK      = 4,
    parameter int unsigned C_CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       blink,
    input  logic       inMode,
    input  logic       inTraffic,
    input  logic       inPedestrian,
    output logic [1:0] outLightMain,
    output logic [1:0] outLightSide,
    output logic       outWalk,
    output logic       outPedAck
);

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        ALL_RED_A,
        WALK,
        SIDE_GREEN,
        SIDE_YELLOW,
        ALL_RED_B,
        FLASH
    } state_t;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_OFF    = 2'b11;

    // Last counter value of each phase: a phase of D ticks ends on the tick seen at cnt == D-1.
    localparam logic [C_CNT_W-1:0] MIN_GREEN_LAST = C_CNT_W'(C_MIN_GREEN - 1);
    localparam logic [C_CNT_W-1:0] SIDE_MIN_LAST  = C_CNT_W'(C_SIDE_MIN - 1);
    localparam logic [C_CNT_W-1:0] SIDE_MAX_LAST  = C_CNT_W'(C_SIDE_MAX - 1);
    localparam logic [C_CNT_W-1:0] YELLOW_LAST    = C_CNT_W'(C_YELLOW - 1);
    localparam logic [C_CNT_W-1:0] ALL_RED_LAST   = C_CNT_W'(C_ALL_RED - 1);
    localparam logic [C_CNT_W-1:0] WALK_LAST      = C_CNT_W'(C_WALK - 1);
    localparam logic [C_CNT_W-1:0] CNT_MAX        = '1;

    state_t             state;
    state_t             state_next;
    logic [C_CNT_W-1:0] cnt;
    logic               traf_req;
    logic               ped_req;
    logic               state_change;

    assign state_change = (state_next != state);

    // State register and phase counter (cleared on every phase change, saturating otherwise).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ALL_RED_B;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_change) begin
                cnt <= '0;
            end else if (tick && (cnt != CNT_MAX)) begin
                cnt <= cnt + C_CNT_W'(1);
            end
        end
    end

    // Request latches; clearing on entry to the serving phase wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            traf_req <= 1'b0;
            ped_req  <= 1'b0;
        end else begin
            if (state_change && (state_next == SIDE_GREEN)) begin
                traf_req <= 1'b0;
            end else if (inTraffic && (state != SIDE_GREEN)) begin
                traf_req <= 1'b1;
            end
            if (state_change && (state_next == WALK)) begin
                ped_req <= 1'b0;
            end else if (inPedestrian && (state != WALK)) begin
                ped_req <= 1'b1;
            end
        end
    end

    // Next-state logic; flashing mode preempts any phase transition.
    always_comb begin
        state_next = state;
        if (inMode && (state != FLASH)) begin
            state_next = FLASH;
        end else begin
            case (state)
                MAIN_GREEN: begin
                    if (tick && (cnt >= MIN_GREEN_LAST) && (traf_req || ped_req)) begin
                        state_next = MAIN_YELLOW;
                    end
                end
                MAIN_YELLOW: begin
                    if (tick && (cnt == YELLOW_LAST)) state_next = ALL_RED_A;
                end
                ALL_RED_A: begin
                    if (tick && (cnt == ALL_RED_LAST)) state_next = ped_req ? WALK : SIDE_GREEN;
                end
                WALK: begin
                    if (tick && (cnt == WALK_LAST)) state_next = traf_req ? SIDE_GREEN : MAIN_GREEN;
                end
                SIDE_GREEN: begin
                    if (tick && (((cnt >= SIDE_MIN_LAST) && !inTraffic) || (cnt == SIDE_MAX_LAST))) begin
                        state_next = SIDE_YELLOW;
                    end
                end
                SIDE_YELLOW: begin
                    if (tick && (cnt == YELLOW_LAST)) state_next = ALL_RED_B;
                end
                ALL_RED_B: begin
                    if (tick && (cnt == ALL_RED_LAST)) state_next = MAIN_GREEN;
                end
                FLASH: begin
                    if (!inMode) state_next = ALL_RED_B;
                end
                default: state_next = ALL_RED_B;
            endcase
        end
    end

    // Moore light decode; only the flashing beat passes through combinationally.
    always_comb begin
        outLightMain = LIGHT_RED;
        outLightSide = LIGHT_RED;
        outWalk      = 1'b0;
        case (state)
            MAIN_GREEN:  outLightMain = LIGHT_GREEN;
            MAIN_YELLOW: outLightMain = LIGHT_YELLOW;
            SIDE_GREEN:  outLightSide = LIGHT_GREEN;
            SIDE_YELLOW: outLightSide = LIGHT_YELLOW;
            WALK:        outWalk      = 1'b1;
            FLASH: begin
                outLightMain = blink ? LIGHT_YELLOW : LIGHT_OFF;
                outLightSide = blink ? LIGHT_RED : LIGHT_OFF;
            end
            default: ;
        endcase
    end

    assign outPedAck = ped_req;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler: per-cycle vector table plus
// multi-cycle sequences for sparse ticks and phase-length measurement.
module tb_crossing_scheduler;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] O = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       blink = 1'b0;
    logic       in_mode = 1'b0;
    logic       in_traffic = 1'b0;
    logic       in_ped = 1'b0;
    logic [1:0] light_main;
    logic [1:0] light_side;
    logic       walk;
    logic       ped_ack;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       tick;
        logic       mode;
        logic       traf;
        logic       ped;
        logic       blink;
        logic [1:0] main;
        logic [1:0] side;
        logic       walk;
        logic       ack;
    } vec_t;

    vec_t vq[$];

    crossing_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .blink        (blink),
        .inMode       (in_mode),
        .inTraffic    (in_traffic),
        .inPedestrian (in_ped),
        .outLightMain (light_main),
        .outLightSide (light_side),
        .outWalk      (walk),
        .outPedAck    (ped_ack)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic t, input logic m, input logic tr,
                                input logic p, input logic b, input logic [1:0] em,
                                input logic [1:0] es, input logic ew, input logic ea);
        vec_t v;
        v.rst = r; v.tick = t; v.mode = m; v.traf = tr; v.ped = p; v.blink = b;
        v.main = em; v.side = es; v.walk = ew; v.ack = ea;
        vq.push_back(v);
    endfunction

    function automatic logic is_go(input logic [1:0] l);
        return (l == G) || (l == Y);
    endfunction

    // One clock edge, then sample 1 time unit later and check the safety invariant.
    task automatic step();
        @(posedge clk);
        #1;
        if (is_go(light_main) && is_go(light_side)) begin
            n_bad++;
            $display("FAIL safety @%0t: main=%b side=%b both moving", $time, light_main, light_side);
        end
    endtask

    task automatic check(input string name, input logic [1:0] em, input logic [1:0] es,
                         input logic ew, input logic ea);
        n_vec++;
        if (light_main !== em || light_side !== es || walk !== ew || ped_ack !== ea) begin
            n_bad++;
            $display("FAIL %s: got main=%b side=%b walk=%b ack=%b, want main=%b side=%b walk=%b ack=%b",
                     name, light_main, light_side, walk, ped_ack, em, es, ew, ea);
        end
    endtask

    // Idle for gap-1 cycles, then one tick cycle.
    task automatic tick_gap(input int gap);
        for (int i = 0; i < gap - 1; i++) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic rep(input int n, input logic t, input logic tr, input logic [1:0] em,
                       input logic [1:0] es, input logic ew, input logic ea);
        for (int i = 0; i < n; i++) add(0, t, 0, tr, 0, 0, em, es, ew, ea);
    endtask

    initial begin
        // rst tick mode traf ped blink | main side walk ack
        add(1, 0, 0, 0, 0, 0, R, R, 0, 0);          // reset -> ALL_RED_B
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);          // all-red 1 tick -> main green
        add(0, 1, 0, 1, 0, 0, G, R, 0, 0);          // traffic pulse early in green
        rep(4, 1, 0, G, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 0);          // 6th tick -> yellow
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 0);          // all-red A
        add(0, 1, 0, 0, 0, 0, R, G, 0, 0);          // side green
        rep(3, 1, 0, R, G, 0, 0);
        add(0, 1, 0, 0, 0, 0, R, Y, 0, 0);          // gap-out after 4 ticks
        add(0, 1, 0, 0, 0, 0, R, Y, 0, 0);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 0);          // all-red B
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);
        add(0, 0, 0, 0, 1, 0, G, R, 0, 1);          // ped pulse, ack at once
        add(0, 0, 0, 0, 0, 0, G, R, 0, 1);
        rep(5, 1, 0, G, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, R, R, 1, 0);          // walk entered, ack cleared
        add(0, 1, 0, 1, 0, 0, R, R, 1, 0);          // traffic arrives during walk
        rep(2, 1, 0, R, R, 1, 0);
        add(0, 1, 0, 1, 0, 0, R, G, 0, 0);          // walk -> side green (trafReq)
        rep(9, 1, 1, R, G, 0, 0);                   // traffic held high
        add(0, 1, 0, 1, 0, 0, R, Y, 0, 0);          // max-out after 10 ticks
        add(0, 1, 0, 1, 0, 0, R, Y, 0, 0);          // trafReq re-sets here
        add(0, 1, 0, 0, 0, 0, R, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);
        rep(5, 1, 0, G, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 0);          // re-served after 6 ticks
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, R, G, 0, 0);
        add(0, 1, 1, 0, 0, 1, Y, R, 0, 0);          // flash entry, blink high
        add(0, 1, 1, 0, 1, 0, O, O, 0, 1);          // blink low, ped latches in flash
        add(0, 1, 1, 0, 0, 1, Y, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 1);          // leave flash -> all-red B
        add(0, 1, 0, 0, 0, 0, G, R, 0, 1);
        rep(5, 1, 0, G, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, Y, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, R, R, 0, 1);
        add(0, 1, 0, 0, 0, 0, R, R, 1, 0);          // walk
        add(0, 1, 0, 1, 1, 0, R, R, 1, 0);          // trafReq set mid-walk
        add(1, 1, 0, 1, 1, 0, R, R, 0, 0);          // reset mid-walk
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);
        rep(5, 1, 0, G, R, 0, 0);
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);          // requests were dropped: hold green
        add(0, 1, 0, 0, 0, 0, G, R, 0, 0);

        #2;
        foreach (vq[i]) begin
            rst = vq[i].rst; tick = vq[i].tick; in_mode = vq[i].mode;
            in_traffic = vq[i].traf; in_ped = vq[i].ped; blink = vq[i].blink;
            step();
            check($sformatf("vec%0d", i), vq[i].main, vq[i].side, vq[i].walk, vq[i].ack);
        end
        rst = 0; tick = 0; in_mode = 0; in_traffic = 0; in_ped = 0; blink = 0;

        // Sparse ticks, no requests: green after one tick, then held indefinitely.
        rst = 1'b1; step(); rst = 1'b0;
        check("seq_reset", R, R, 0, 0);
        tick_gap(10);
        check("seq_first_green", G, R, 0, 0);
        for (int k = 0; k < 50; k++) begin
            tick_gap(10);
            check($sformatf("seq_hold%0d", k), G, R, 0, 0);
        end

        // Gap-out measured with ticks every 3 cycles: 4 green ticks, 2 yellow.
        begin
            int g_ticks = 0;
            int y_ticks = 0;
            bit seen_side = 0;
            bit done = 0;
            logic [1:0] prev;
            in_traffic = 1'b1; step(); in_traffic = 1'b0;
            for (int k = 0; k < 100 && !done; k++) begin
                prev = light_side;
                tick_gap(3);
                if (prev == G) g_ticks++;
                if (prev == Y) y_ticks++;
                if (light_side == G) seen_side = 1;
                if (seen_side && light_main == G) done = 1;
            end
            n_vec++;
            if (!done || g_ticks != 4 || y_ticks != 2) begin
                n_bad++;
                $display("FAIL seq_sparse_gapout: done=%0d green_ticks=%0d yellow_ticks=%0d, want done=1 green=4 yellow=2",
                         done, g_ticks, y_ticks);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/crossing_scheduler.md
Name: crossing_scheduler

Overview:
- Sequences right-of-way at a two-road crossing (main road and side road) with a shared pedestrian walk phase.
- Main road rests on green. Side-road traffic and pedestrian requests are latched and served in a fixed order, with yellow and all-red clearance between phases.
- Timing is counted in ticks of an external 1-cycle strobe from the period divider. A flashing-mode override uses the shared blink beat.
- Sits above the per-light decode/driver logic and replaces single-road sequencing at intersections.

Parameters:
- C_MIN_GREEN, 6: minimum main green, in ticks.
- C_SIDE_MIN, 4: minimum side green, in ticks.
- C_SIDE_MAX, 10: maximum side green, in ticks. Must be >= C_SIDE_MIN.
- C_YELLOW, 2: yellow duration for either road, in ticks.
- C_ALL_RED, 1: all-red clearance, in ticks.
- C_WALK, 4: walk phase duration, in ticks.
- C_CNT_W, 8: phase counter width. Must hold max(all durations).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  1-cycle timing strobe; all durations count these.
- blink  in  1  flashing-mode beat (level).
- inMode  in  1  1 = flashing mode, 0 = normal sequencing.
- inTraffic  in  1  side-road vehicle detector (level).
- inPedestrian  in  1  pedestrian button (level or pulse).
- outLightMain  out  2  main road light: 00 RED, 01 GREEN, 10 YELLOW, 11 OFF.
- outLightSide  out  2  side road light, same encoding.
- outWalk  out  1  pedestrian walk lamp.
- outPedAck  out  1  "request registered" lamp; equals the pedReq latch.

Behaviour:
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, WALK, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, FLASH.
- Phase counter `cnt`:
  - Cleared to 0 on every state change.
  - Otherwise increments on tick and saturates at all-ones.
- "Expires(D)" means tick=1 and cnt==D-1. A phase therefore lasts exactly D ticks after entry.
- Reset (rst=1 at a clk edge):
  - state=ALL_RED_B, cnt=0, trafReq=0, pedReq=0.
  - Outputs: main RED, side RED, outWalk=0, outPedAck=0.
  - rst overrides all other inputs. Reset mid-phase abandons the phase immediately.
- Request latches:
  - trafReq is set on any cycle with inTraffic=1 while the state is not SIDE_GREEN. It is cleared on the cycle SIDE_GREEN is entered.
  - pedReq is set on any cycle with inPedestrian=1 while the state is not WALK. It is cleared on the cycle WALK is entered.
  - Clear-on-entry has priority over set in the same cycle.
- Transitions when inMode=0:
  - MAIN_GREEN -> MAIN_YELLOW: on tick with cnt>=C_MIN_GREEN-1 and (trafReq|pedReq). With no requests, main green is held indefinitely.
  - MAIN_YELLOW -> ALL_RED_A: on Expires(C_YELLOW).
  - ALL_RED_A -> WALK if pedReq, else -> SIDE_GREEN: on Expires(C_ALL_RED).
  - WALK -> SIDE_GREEN if trafReq, else -> MAIN_GREEN: on Expires(C_WALK). All vehicle lights are red during WALK, so no extra clearance is needed.
  - SIDE_GREEN -> SIDE_YELLOW:
    - on tick with cnt>=C_SIDE_MIN-1 and inTraffic=0 (gap-out), or
    - on Expires(C_SIDE_MAX) regardless of inTraffic (max-out).
  - SIDE_YELLOW -> ALL_RED_B: on Expires(C_YELLOW).
  - ALL_RED_B -> MAIN_GREEN: on Expires(C_ALL_RED).
- Flashing mode:
  - If inMode=1 in any non-FLASH state, go to FLASH on the next edge. This takes priority over any phase transition in that cycle.
  - FLASH -> ALL_RED_B when inMode=0, so there is always a clearance before main green.
  - Requests keep latching during FLASH and are served normally afterwards.
- Output decode is a Moore decode of the state register; there is no extra pipeline stage.
  - MAIN_GREEN: main GREEN, side RED.
  - MAIN_YELLOW: main YELLOW, side RED.
  - SIDE_GREEN: main RED, side GREEN.
  - SIDE_YELLOW: main RED, side YELLOW.
  - ALL_RED_A, ALL_RED_B, WALK: main RED, side RED.
  - FLASH: main = blink ? YELLOW : OFF; side = blink ? RED : OFF. The blink term is combinational.
  - outWalk=1 only in WALK.
- Safety invariant: main and side are never both in {GREEN, YELLOW} in the same cycle.
- The tick count within a phase is unaffected by clk-to-tick ratio; tick=1 on consecutive cycles is legal.

Test Plan:
- Reset, then tick every 10 cycles with no requests -> main GREEN after exactly 1 tick (ALL_RED_B). Then main stays GREEN for >=50 ticks; outWalk=0 and outPedAck=0 throughout.
- inTraffic pulsed 1 cycle at tick 2 of MAIN_GREEN, held low afterwards -> main GREEN lasts 6 ticks, then YELLOW 2, all-red 1. Side GREEN lasts 4 ticks (gap-out), then YELLOW 2, all-red 1, then main GREEN. trafReq is cleared at side-green entry.
- inTraffic held high continuously -> side GREEN lasts exactly 10 ticks (max-out). trafReq re-sets during SIDE_YELLOW, so the next cycle repeats after 6 ticks of main green.
- inPedestrian pulse during MAIN_GREEN, no traffic -> outPedAck=1 immediately. Sequence: YELLOW 2, all-red 1, WALK 4 ticks (outWalk=1, outPedAck=0), then main GREEN. Repeat with inTraffic=1 as well -> WALK is followed by SIDE_GREEN.
- inMode=1 mid SIDE_GREEN -> FLASH on the next edge; main toggles YELLOW/OFF and side toggles RED/OFF with blink. inMode=0 -> 1 tick all-red, then main GREEN.
- rst asserted for 1 cycle mid-WALK with pedReq/trafReq set -> next cycle both lights RED, outWalk=0, outPedAck=0. Checker asserts the safety invariant on every cycle of every test.
